bram_delay_ctrl: RTL



---
 rtl/bram_delay_ctrl_if.sv | 23 ++
 rtl/bram_delay_ctrl.sv | 87 ++++++++
 2 files changed

// File: rtl/bram_delay_ctrl_if.sv
// bram_delay_ctrl_if: config handshake and RAM-port bundle for bram_delay_ctrl.
// slave is the sequencer side, master is the config/RAM-owner side.
interface bram_delay_ctrl_if #(parameter int ADDR_BITS = 10);
  logic                 ce;
  logic [ADDR_BITS:0]   cfg_delay;
  logic                 cfg_valid;
  logic                 cfg_ready;
  logic                 cfg_err;
  logic                 ram_we;
  logic [ADDR_BITS-1:0] ram_waddr;
  logic [ADDR_BITS-1:0] ram_raddr;
  logic                 dout_valid;
  logic [ADDR_BITS:0]   delay_cur;
  logic                 busy;
  modport slave (
    input  ce, cfg_delay, cfg_valid,
    output cfg_ready, cfg_err, ram_we, ram_waddr, ram_raddr, dout_valid, delay_cur, busy
  );
  modport master (
    output ce, cfg_delay, cfg_valid,
    input  cfg_ready, cfg_err, ram_we, ram_waddr, ram_raddr, dout_valid, delay_cur, busy
  );
endinterface

// File: rtl/bram_delay_ctrl.sv
// bram_delay_ctrl: runtime-programmable address sequencer for a BRAM delay line.
// Define BRAM_DELAY_CTRL_RANGE_CHECK_EN to reject out-of-range delays with cfg_err instead of clamping.
module bram_delay_ctrl #(
  parameter int ADDR_BITS     = 10,
  parameter int RAM_LATENCY   = 2,
  parameter int DEFAULT_DELAY = 1024
) (
  input logic              clk,
  input logic              rst_n,
  bram_delay_ctrl_if.slave bus
);
  localparam logic [ADDR_BITS:0]   MIN_DELAY = (ADDR_BITS+1)'(RAM_LATENCY + 1);
  localparam logic [ADDR_BITS:0]   MAX_DELAY = (ADDR_BITS+1)'(1 << ADDR_BITS);
  localparam logic [ADDR_BITS:0]   ONE_D     = 1;
  localparam logic [ADDR_BITS-1:0] ONE_A     = 1;
  typedef enum logic [1:0] {LOAD, PRIME, RUN} state_t;
  state_t               state_q, state_d;
  logic [ADDR_BITS-1:0] wptr_q, wptr_d, raddr_q, raddr_d, offset_q, offset_d;
  logic [ADDR_BITS:0]   delay_q, delay_d, prime_q, prime_d, req;
  logic                 err_q, err_d, fire, apply;
  assign fire = bus.cfg_valid & bus.ce & (state_q != LOAD);
`ifdef BRAM_DELAY_CTRL_RANGE_CHECK_EN
  logic bad;
  assign bad   = (bus.cfg_delay < MIN_DELAY) || (bus.cfg_delay > MAX_DELAY);
  assign req   = bus.cfg_delay;
  assign apply = fire & ~bad;
  assign err_d = fire & bad;
`else
  assign req   = bus.cfg_delay < MIN_DELAY ? MIN_DELAY : bus.cfg_delay > MAX_DELAY ? MAX_DELAY : bus.cfg_delay;
  assign apply = fire;
  assign err_d = 1'b0;
`endif
  // raddr_q is precomputed from the next wptr so it lines up with ram_waddr in the same cycle
  always_comb begin
    state_d  = state_q;
    wptr_d   = wptr_q;
    raddr_d  = raddr_q;
    offset_d = offset_q;
    delay_d  = delay_q;
    prime_d  = prime_q;
    if (bus.ce) begin
      if (state_q == LOAD) begin
        offset_d = ADDR_BITS'(delay_q - RAM_LATENCY);
        raddr_d  = wptr_q - offset_d;
        prime_d  = '0;
        state_d  = PRIME;
      end else begin
        wptr_d  = wptr_q + ONE_A;
        raddr_d = wptr_d - offset_q;
        if (apply) begin
          delay_d = req;
          state_d = LOAD;
        end else if (state_q == PRIME) begin
          prime_d = prime_q + ONE_D;
          state_d = (prime_q == delay_q - ONE_D) ? RUN : PRIME;
        end
      end
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= LOAD;
      wptr_q   <= '0;
      raddr_q  <= '0;
      offset_q <= '0;
      delay_q  <= (ADDR_BITS+1)'(DEFAULT_DELAY);
      prime_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wptr_q   <= wptr_d;
      raddr_q  <= raddr_d;
      offset_q <= offset_d;
      delay_q  <= delay_d;
      prime_q  <= prime_d;
      err_q    <= err_d;
    end
  end
  assign bus.cfg_ready  = state_q != LOAD;
  assign bus.cfg_err    = err_q;
  assign bus.ram_we     = bus.ce & (state_q != LOAD);
  assign bus.ram_waddr  = wptr_q;
  assign bus.ram_raddr  = raddr_q;
  assign bus.dout_valid = state_q == RUN;
  assign bus.busy       = state_q != RUN;
  assign bus.delay_cur  = delay_q;
endmodule
